// File: rtl/sram_controller_pkg.sv
// ============================================================================
// Module : sram_controller_pkg
// Brief  : Shared constants, FSM state encoding and address helper for the
//          16-bit asynchronous SRAM data-memory controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sram_controller_pkg;

  localparam int WORD_WIDTH    = 32;
  localparam int SRAM_ADDR_LEN = 18;
  localparam int SRAM_DATA_LEN = 16;
  localparam int DATA_MEM_BASE = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Word index of a byte address relative to the data-memory base; the byte
  // offset bits and anything above the SRAM word range are discarded.
  function automatic logic [SRAM_ADDR_LEN-2:0] word_index(
    input logic [WORD_WIDTH-1:0] byte_addr,
    input logic [WORD_WIDTH-1:0] base
  );
    return (SRAM_ADDR_LEN-1)'((byte_addr - base) >> 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_controller.sv
// ============================================================================
// Module : sram_controller
// Brief  : Splits each 32-bit load/store into two 16-bit asynchronous SRAM
//          phases (low half first), stalling the pipeline through ready.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = 3,
  parameter int BASE_ADDR   = DATA_MEM_BASE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [WORD_WIDTH-1:0]    addr,
  input  logic [WORD_WIDTH-1:0]    write_data,
  output logic [WORD_WIDTH-1:0]    read_data,
  output logic                     ready,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
  input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
  output logic                     sram_dq_oe,
  output logic                     sram_we_n
);

  localparam logic [3:0]            LAST_CNT = 4'(WAIT_CYCLES - 1);
  localparam logic [WORD_WIDTH-1:0] BASE_W   = WORD_WIDTH'(BASE_ADDR);

  state_e                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic                     write_q, write_d;
  logic [SRAM_ADDR_LEN-2:0] idx_q, idx_d;
  logic [WORD_WIDTH-1:0]    wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0]    rdata_q, rdata_d;
  logic [SRAM_ADDR_LEN-1:0] sram_addr_q, sram_addr_d;
  logic [SRAM_DATA_LEN-1:0] dq_out_q, dq_out_d;
  logic                     oe_q, oe_d;
  logic                     we_n_q, we_n_d;

  logic                     req;
  logic                     last;
  logic [3:0]               cnt_inc;
  logic [SRAM_ADDR_LEN-2:0] req_idx;

  assign req     = mem_read | mem_write;
  assign last    = (cnt_q == LAST_CNT);
  assign cnt_inc = cnt_q + 4'd1;
  assign req_idx = word_index(addr, BASE_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      oe_q        <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      oe_q        <= oe_d;
      we_n_q      <= we_n_d;
    end
  end

  // SRAM pins are registered, so each branch computes what the pins must
  // show during the *next* cycle. The first cycle of a phase always strobes
  // we_n on a write (also covers WAIT_CYCLES=1); the last cycle is the hold.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    oe_d        = oe_q;
    we_n_d      = we_n_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d     = ST_LOW;
          cnt_d       = 4'd0;
          write_d     = mem_write;
          idx_d       = req_idx;
          wdata_d     = write_data;
          sram_addr_d = {req_idx, 1'b0};
          dq_out_d    = write_data[15:0];
          oe_d        = mem_write;
          we_n_d      = ~mem_write;
        end
      end
      ST_LOW: begin
        if (last) begin
          state_d     = ST_HIGH;
          cnt_d       = 4'd0;
          sram_addr_d = {idx_q, 1'b1};
          dq_out_d    = wdata_q[31:16];
          we_n_d      = ~write_q;
          if (!write_q) rdata_d[15:0] = sram_dq_in;
        end else begin
          cnt_d  = cnt_inc;
          we_n_d = ~(write_q && (cnt_inc != LAST_CNT));
        end
      end
      ST_HIGH: begin
        if (last) begin
          state_d = ST_DONE;
          cnt_d   = 4'd0;
          oe_d    = 1'b0;
          we_n_d  = 1'b1;
          if (!write_q) rdata_d[31:16] = sram_dq_in;
        end else begin
          cnt_d  = cnt_inc;
          we_n_d = ~(write_q && (cnt_inc != LAST_CNT));
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ready       = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
  assign read_data   = rdata_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_controller.sv
// ============================================================================
// Module : tb_sram_controller
// Brief  : Directed bench for sram_controller (W=3 and W=1 instances, each
//          backed by a behavioural asynchronous 16-bit SRAM).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sram_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // W=3 instance
  logic        mem_read0 = 1'b0, mem_write0 = 1'b0;
  logic [31:0] addr0 = '0, write_data0 = '0, read_data0;
  logic        ready0, sram_dq_oe0, sram_we_n0;
  logic [17:0] sram_addr0;
  logic [15:0] sram_dq_out0, sram_dq_in0;
  logic [15:0] mem0 [0:(1<<18)-1];

  // W=1 instance
  logic        mem_read1 = 1'b0, mem_write1 = 1'b0;
  logic [31:0] addr1 = '0, write_data1 = '0, read_data1;
  logic        ready1, sram_dq_oe1, sram_we_n1;
  logic [17:0] sram_addr1;
  logic [15:0] sram_dq_out1, sram_dq_in1;
  logic [15:0] mem1 [0:(1<<18)-1];

  int total = 0;
  int bad   = 0;

  sram_controller #(.WAIT_CYCLES(3), .BASE_ADDR(1024)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read0), .mem_write(mem_write0),
    .addr(addr0), .write_data(write_data0), .read_data(read_data0),
    .ready(ready0), .sram_addr(sram_addr0), .sram_dq_out(sram_dq_out0),
    .sram_dq_in(sram_dq_in0), .sram_dq_oe(sram_dq_oe0), .sram_we_n(sram_we_n0)
  );

  sram_controller #(.WAIT_CYCLES(1), .BASE_ADDR(1024)) dut1 (
    .clk(clk), .rst(rst),
    .mem_read(mem_read1), .mem_write(mem_write1),
    .addr(addr1), .write_data(write_data1), .read_data(read_data1),
    .ready(ready1), .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1),
    .sram_dq_in(sram_dq_in1), .sram_dq_oe(sram_dq_oe1), .sram_we_n(sram_we_n1)
  );

  // Asynchronous-read SRAMs; a write lands while we_n is low and DQ is driven.
  assign sram_dq_in0 = mem0[sram_addr0];
  assign sram_dq_in1 = mem1[sram_addr1];

  always @(posedge clk) begin
    if (!sram_we_n0 && sram_dq_oe0) mem0[sram_addr0] <= sram_dq_out0;
    if (!sram_we_n1 && sram_dq_oe1) mem1[sram_addr1] <= sram_dq_out1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access on the W=3 instance, entered in an IDLE cycle; returns in DONE.
  task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [17:0] exp_lo,
                        input logic [31:0] exp_rd);
    logic [15:0] exp_dq;
    mem_write0 = wr; mem_read0 = rd; addr0 = a; write_data0 = d;
    #1;
    check("ready_c0", {31'd0, ready0}, 32'd0);
    for (int c = 1; c <= 6; c++) begin
      step();
      exp_dq = (c <= 3) ? d[15:0] : d[31:16];
      check("ready_busy", {31'd0, ready0}, 32'd0);
      check("sram_addr", {14'd0, sram_addr0}, {14'd0, exp_lo | 18'(c > 3)});
      check("oe", {31'd0, sram_dq_oe0}, {31'd0, wr});
      check("we_n", {31'd0, sram_we_n0}, {31'd0, (!wr) || (c % 3 == 0)});
      if (wr) check("dq_out", {16'd0, sram_dq_out0}, {16'd0, exp_dq});
    end
    step();
    check("ready_done", {31'd0, ready0}, 32'd1);
    check("we_n_done", {31'd0, sram_we_n0}, 32'd1);
    check("oe_done", {31'd0, sram_dq_oe0}, 32'd0);
    check("read_data", read_data0, exp_rd);
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    check("rst_ready", {31'd0, ready0}, 32'd1);
    check("rst_we_n", {31'd0, sram_we_n0}, 32'd1);
    check("rst_oe", {31'd0, sram_dq_oe0}, 32'd0);
    check("rst_rdata", read_data0, 32'd0);
    check("rst_addr", {14'd0, sram_addr0}, 32'd0);
    step();
    check("idle_ready", {31'd0, ready0}, 32'd1);
    check("idle_we_n", {31'd0, sram_we_n0}, 32'd1);

    // W=1, read and write both high: write wins, ready at cycle 3
    mem_read1 = 1'b1; mem_write1 = 1'b1; addr1 = 32'd1024; write_data1 = 32'hA5A55A5A;
    #1;
    check("w1_ready_c0", {31'd0, ready1}, 32'd0);
    step();
    check("w1_c1_addr", {14'd0, sram_addr1}, 32'd0);
    check("w1_c1_we_n", {31'd0, sram_we_n1}, 32'd0);
    check("w1_c1_oe", {31'd0, sram_dq_oe1}, 32'd1);
    check("w1_c1_dq", {16'd0, sram_dq_out1}, 32'h5A5A);
    check("w1_c1_ready", {31'd0, ready1}, 32'd0);
    step();
    check("w1_c2_addr", {14'd0, sram_addr1}, 32'd1);
    check("w1_c2_we_n", {31'd0, sram_we_n1}, 32'd0);
    check("w1_c2_dq", {16'd0, sram_dq_out1}, 32'hA5A5);
    check("w1_c2_ready", {31'd0, ready1}, 32'd0);
    step();
    check("w1_c3_ready", {31'd0, ready1}, 32'd1);
    check("w1_c3_we_n", {31'd0, sram_we_n1}, 32'd1);
    check("w1_rdata", read_data1, 32'd0);
    step();
    mem_read1 = 1'b0; mem_write1 = 1'b0;
    #1;
    check("w1_mem_lo", {16'd0, mem1[0]}, 32'h5A5A);
    check("w1_mem_hi", {16'd0, mem1[1]}, 32'hA5A5);
    check("w1_idle_ready", {31'd0, ready1}, 32'd1);

    // Store then load at 1028, back-to-back 1032 store/load
    access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 18'd2, 32'd0);
    step();
    check("st_mem_lo", {16'd0, mem0[2]}, 32'hBEEF);
    check("st_mem_hi", {16'd0, mem0[3]}, 32'hDEAD);
    access(1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 32'hDEADBEEF);
    step();
    access(1'b1, 1'b0, 32'd1032, 32'h12345678, 18'd4, 32'hDEADBEEF);
    step();
    access(1'b0, 1'b1, 32'd1032, 32'h0, 18'd4, 32'h12345678);
    step();

    // Store to 1036, reset asserted in first HIGH cycle
    mem_write0 = 1'b1; mem_read0 = 1'b0; addr0 = 32'd1036; write_data0 = 32'hCAFEF00D;
    for (int c = 1; c <= 4; c++) step();
    check("pre_rst_addr", {14'd0, sram_addr0}, 32'd7);
    rst = 1'b1; mem_write0 = 1'b0;
    step();
    check("abort_we_n", {31'd0, sram_we_n0}, 32'd1);
    check("abort_oe", {31'd0, sram_dq_oe0}, 32'd0);
    check("abort_rdata", read_data0, 32'd0);
    check("abort_ready", {31'd0, ready0}, 32'd1);
    rst = 1'b0;
    step();
    check("post_rst_ready", {31'd0, ready0}, 32'd1);
    access(1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 32'hDEADBEEF);
    step();
    mem_read0 = 1'b0;
    #1;
    check("final_idle_ready", {31'd0, ready0}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_controller.md
# sram_controller

Sequencer that replaces the single-cycle on-chip data memory behind the memory stage with an off-chip 16-bit asynchronous SRAM. It accepts one 32-bit load or store per request from the memory stage and splits it into two 16-bit SRAM phases, low half first. It holds `ready` low while busy so the hazard/freeze logic stalls the whole pipeline. It returns 32-bit read data aligned with `ready`.

## Interface
Parameters:
- `WAIT_CYCLES`, default 3: cycles each SRAM phase holds address/data/strobes; legal range 1..15.
- `BASE_ADDR`, default 1024: byte address of data-memory word 0.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_read` in 1: load request from the memory stage, level.
- `mem_write` in 1: store request from the memory stage, level.
- `addr` in `WORD_WIDTH` (32): byte address, the ALU result.
- `write_data` in 32: store data, the Rm value.
- `read_data` out 32: load result, valid while `ready`=1 in DONE.
- `ready` out 1: 0 freezes the pipeline.
- `sram_addr` out `SRAM_ADDR_LEN` (18): SRAM half-word address.
- `sram_dq_out` out 16: SRAM write data.
- `sram_dq_in` in 16: SRAM read data.
- `sram_dq_oe` out 1: drive enable for the top-level tri-state DQ buffer.
- `sram_we_n` out 1: SRAM write strobe, active low.

## Operation
- Address map:
  - Word index = (`addr` − `BASE_ADDR`) >> 2, truncated to 17 bits.
  - Low half: `sram_addr` = {idx, 0}.
  - High half: `sram_addr` = {idx, 1}.
  - `addr[1:0]` is ignored.
- FSM states and transitions:
  - IDLE: waits for a request. On `mem_read` or `mem_write`, latches addr/write_data/op and goes to LOW. With no request, stays in IDLE.
  - LOW: drives the low half for `WAIT_CYCLES` cycles, then goes to HIGH.
  - HIGH: drives the high half for `WAIT_CYCLES` cycles, then goes to DONE.
  - DONE: one cycle, then IDLE.
- Simultaneous `mem_read` and `mem_write`: illegal. The controller executes a write.
- Phase counter: 4-bit, cleared on each phase entry. The phase ends when counter = `WAIT_CYCLES`−1.
- Writes:
  - `sram_dq_oe`=1 throughout LOW and HIGH. `sram_dq_out` = latched data[15:0] in LOW, [31:16] in HIGH.
  - `sram_we_n`=0 in every cycle of a phase except its last. That last cycle gives data/address hold with `we_n` high.
  - If `WAIT_CYCLES`=1, `we_n` is low for the single cycle.
- Reads:
  - `sram_dq_oe`=0 and `we_n`=1.
  - `sram_dq_in` is captured into read_data[15:0] on the last LOW cycle and into [31:16] on the last HIGH cycle.
- `ready` (combinational):
  - 1 in IDLE when no request is asserted.
  - 1 in DONE.
  - 0 otherwise, including the IDLE cycle in which a request is first seen.
- `read_data`: holds its value until the next read overwrites it. A write does not alter it.
- Inputs are sampled only in IDLE. Changes during LOW/HIGH/DONE are ignored.

## Timing
- Reset (synchronous): state=IDLE, counter=0, `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0, `read_data`=0.
  - `ready` follows combinationally (1 if no request).
  - Reset mid-access aborts immediately. The half-written word is undefined and no completion is signalled.
- All SRAM outputs are registered, changing only on `clk` rising edges.
- Latency: request seen in IDLE at cycle 0. LOW occupies cycles 1..W, HIGH occupies cycles W+1..2W, and DONE with `ready`=1 is cycle 2W+1. Default W=3: `ready` at cycle 7, so the pipeline freezes for 7 cycles.
- After DONE the pipeline has advanced. A request seen in the following IDLE cycle belongs to the next instruction, and back-to-back accesses start without a bubble.
- No request at all: `ready` stays 1 and the SRAM stays idle (`we_n`=1, `oe`=0).

## Structure
- Constants go in the shared defines header:
  - `WORD_WIDTH`=32, `SRAM_ADDR_LEN`=18, `SRAM_DATA_LEN`=16, `DATA_MEM_BASE`=1024.
  - State encodings IDLE/LOW/HIGH/DONE.
- Single module. No sub-module is needed; the phase counter is inline.
- A behavioural 16-bit SRAM model (asynchronous read, write on `we_n` low) lives only in the testbench.
- The top level owns the tri-state: DQ = `sram_dq_oe` ? `sram_dq_out` : 16'bz.

## Test plan
- Reset, then idle: `ready`=1, `we_n`=1, `oe`=0, `read_data`=0, `sram_addr`=0.
- Store `addr`=1028, data 0xDEADBEEF, W=3 -> `sram_addr` 2 then 3. DQ carries 0xBEEF then 0xDEAD. `we_n` is low for 2 of the 3 cycles of each phase. `ready` is low for cycles 0..6 and high at cycle 7.
- Load from 1028 after that store -> `read_data`=0xDEADBEEF with `ready`=1 at cycle 7; `oe`=0 throughout.
- Back-to-back store to 1032 (0x12345678) then load from 1032, no idle gap -> second access starts the cycle after DONE and returns 0x12345678.
- Assert `rst` during HIGH of a store -> next cycle state is IDLE, `we_n`=1, `oe`=0, `read_data`=0. A subsequent load completes normally in 2W+1 cycles.
- `mem_read` and `mem_write` both high with W=1 -> write is executed and `ready` rises at cycle 3.
